// File: rtl/instr_fetch.sv
// instr_fetch: holds the fetch PC, issues in-order imem requests and buffers
// returned words with their PC in a ring presented to decode.
module instr_fetch #(
    parameter int unsigned          wd_instr_p = 32,
    parameter int unsigned          wd_addr_p  = 32,
    parameter logic [wd_addr_p-1:0] reset_pc_p = '0,
    parameter int unsigned          depth_p    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_imem_req,
    output logic [wd_addr_p-1:0]  o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [wd_instr_p-1:0] i_imem_rdata,
    output logic                  o_instr_valid,
    output logic [wd_instr_p-1:0] o_instr,
    output logic [wd_addr_p-1:0]  o_pc,
    input  logic                  i_instr_ready,
    input  logic                  i_redirect_valid,
    input  logic [wd_addr_p-1:0]  i_redirect_pc
);
    localparam int unsigned     aw_p  = $clog2(depth_p);
    localparam logic [aw_p+1:0] cap_p = (aw_p+2)'(depth_p);
    localparam logic [aw_p:0]   one_p = (aw_p+1)'(1);

    logic [wd_addr_p-1:0]  r_pc;
    logic [wd_addr_p-1:0]  r_buf_pc    [depth_p];
    logic [wd_instr_p-1:0] r_buf_instr [depth_p];
    logic [depth_p-1:0]    r_filled;
    logic [aw_p:0]         r_alloc_ptr, r_fill_ptr, r_rd_ptr, r_discard;
    logic [aw_p:0]         w_count, w_unfilled, w_redir_discard;
    logic [aw_p+1:0]       w_occ, w_pending;
    logic [aw_p-1:0]       w_alloc_idx, w_fill_idx, w_rd_idx;
    logic                  w_alloc, w_fill, w_drop, w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        w_count         = r_alloc_ptr - r_rd_ptr;
        w_unfilled      = r_alloc_ptr - r_fill_ptr;
        w_occ           = {1'b0, w_count} + {1'b0, r_discard};
        w_pending       = {1'b0, w_unfilled} + {1'b0, r_discard};
        w_redir_discard = (aw_p+1)'(w_pending - (aw_p+2)'(i_imem_rvalid && w_pending != '0));
        w_alloc_idx     = r_alloc_ptr[aw_p-1:0];
        w_fill_idx      = r_fill_ptr[aw_p-1:0];
        w_rd_idx        = r_rd_ptr[aw_p-1:0];
        o_imem_req      = !rst && !i_redirect_valid && (w_occ < cap_p);
        o_imem_addr     = r_pc;
        o_instr_valid   = r_filled[w_rd_idx] && !i_redirect_valid;
        o_instr         = r_buf_instr[w_rd_idx];
        o_pc            = r_buf_pc[w_rd_idx];
        w_alloc         = o_imem_req && i_imem_gnt;
        w_drop          = i_imem_rvalid && r_discard != '0;
        w_fill          = i_imem_rvalid && r_discard == '0 && w_unfilled != '0;
        w_pop           = o_instr_valid && i_instr_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || i_redirect_valid) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_filled    <= '0;
            for (int i = 0; i < int'(depth_p); i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_buf_pc[w_alloc_idx] <= r_pc;
                r_filled[w_alloc_idx] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + one_p;
            end
            if (w_fill) begin
                r_buf_instr[w_fill_idx] <= i_imem_rdata;
                r_filled[w_fill_idx]    <= 1'b1;
                r_fill_ptr              <= r_fill_ptr + one_p;
            end
            if (w_pop) begin
                r_filled[w_rd_idx] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + one_p;
            end
        end
        // Words still owed by memory for flushed fetches are dropped on return.
        if (rst) begin
            r_pc      <= reset_pc_p;
            r_discard <= '0;
        end else if (i_redirect_valid) begin
            r_pc      <= i_redirect_pc & ~wd_addr_p'(3);
            r_discard <= w_redir_discard;
        end else begin
            if (w_alloc) r_pc <= r_pc + wd_addr_p'(4);
            if (w_drop) r_discard <= r_discard - one_p;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus stall, redirect, wrap and
// randomized sequences against a PC reference model and an imem responder.
module tb_instr_fetch;
    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        gnt    = 1'b0;
    logic        rvalid = 1'b0;
    logic        ready  = 1'b0;
    logic        redir  = 1'b0;
    logic [31:0] rdata  = '0;
    logic [31:0] rpc    = '0;
    logic        req, valid, w_req, w_valid;
    logic [31:0] addr, instr, pc, w_addr, w_instr, w_pc;

    instr_fetch u_dut (
        .clk(clk), .rst(rst),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_instr_valid(valid), .o_instr(instr), .o_pc(pc), .i_instr_ready(ready),
        .i_redirect_valid(redir), .i_redirect_pc(rpc)
    );

    instr_fetch #(.reset_pc_p(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_instr_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc), .i_instr_ready(ready),
        .i_redirect_valid(redir), .i_redirect_pc(rpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    typedef struct {
        int          gnt, rdy, redir;
        logic [31:0] rpc;
        int          req;
        logic [31:0] addr;
        int          vld;
        logic [31:0] pc;
    } vec_t;

    rsp_t q[$];
    vec_t vecs[23];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   lat     = 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs are applied at the negedge; outputs are sampled 1 time unit later.
    task automatic settle();
        rvalid = 1'b0;
        rdata  = '0;
        if (q.size() != 0 && q[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem(q[0].addr);
        end
        #1;
    endtask

    task automatic advance();
        int due;
        if (rst) q.delete();
        else begin
            if (rvalid) void'(q.pop_front());
            if (req && gnt) begin
                due = cyc + lat;
                if (q.size() != 0 && q[$].due >= due) due = q[$].due + 1;
                q.push_back('{addr, due});
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        gnt   = 1'b0;
        ready = 1'b0;
        redir = 1'b0;
        lat   = 1;
        settle();
        chk("rst_req", 32'(req), 0);
        advance();
        rst = 1'b0;
    endtask

    initial begin
        int          hs, held, pops;
        bit          done;
        logic [31:0] exp_pc, exp_fpc;
        logic [31:0] wexp[3];
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs = '{
            '{1, 1, 0, 32'h0,   1, 32'h000, 0, 32'h0},
            '{1, 1, 0, 32'h0,   1, 32'h004, 0, 32'h0},
            '{1, 1, 0, 32'h0,   1, 32'h008, 1, 32'h000},
            '{1, 1, 0, 32'h0,   1, 32'h00C, 1, 32'h004},
            '{1, 1, 0, 32'h0,   1, 32'h010, 1, 32'h008},
            '{1, 0, 0, 32'h0,   1, 32'h014, 1, 32'h00C},
            '{1, 0, 0, 32'h0,   1, 32'h018, 1, 32'h00C},
            '{1, 0, 0, 32'h0,   0, 32'h01C, 1, 32'h00C},
            '{1, 0, 0, 32'h0,   0, 32'h01C, 1, 32'h00C},
            '{1, 1, 0, 32'h0,   0, 32'h01C, 1, 32'h00C},
            '{1, 1, 0, 32'h0,   1, 32'h01C, 1, 32'h010},
            '{1, 1, 0, 32'h0,   1, 32'h020, 1, 32'h014},
            '{1, 1, 0, 32'h0,   1, 32'h024, 1, 32'h018},
            '{0, 1, 0, 32'h0,   1, 32'h028, 1, 32'h01C},
            '{0, 1, 0, 32'h0,   1, 32'h028, 1, 32'h020},
            '{1, 1, 0, 32'h0,   1, 32'h028, 1, 32'h024},
            '{1, 1, 0, 32'h0,   1, 32'h02C, 0, 32'h0},
            '{1, 1, 0, 32'h0,   1, 32'h030, 1, 32'h028},
            '{1, 1, 1, 32'h203, 0, 32'h034, 0, 32'h0},
            '{1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0},
            '{1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0},
            '{1, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200},
            '{1, 1, 0, 32'h0,   1, 32'h20C, 1, 32'h204}
        };

        // Reset values, then PC wrap on the instance reset near the top of memory.
        reset_dut();
        gnt   = 1'b1;
        ready = 1'b1;
        settle();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", addr, 0);
        for (int c = 0; c < 3; c++) begin
            if (c != 0) settle();
            chk($sformatf("wrap_req%0d", c), 32'(w_req), 1);
            chk($sformatf("wrap_addr%0d", c), w_addr, wexp[c]);
            advance();
        end

        // Cycle-by-cycle vector table, 1-cycle memory latency.
        reset_dut();
        for (int i = 0; i < 23; i++) begin
            gnt   = vecs[i].gnt != 0;
            ready = vecs[i].rdy != 0;
            redir = vecs[i].redir != 0;
            rpc   = vecs[i].rpc;
            settle();
            chk($sformatf("vec%0d_req", i), 32'(req), 32'(vecs[i].req));
            chk($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].vld));
            if (vecs[i].vld != 0) begin
                chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
                chk($sformatf("vec%0d_instr", i), instr, mem(vecs[i].pc));
            end
            advance();
        end
        redir = 1'b0;

        // Decode stalled from reset: exactly depth_p requests, head held.
        reset_dut();
        gnt  = 1'b1;
        hs   = 0;
        held = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (req && gnt) hs++;
            if (valid && pc == 32'h0 && instr == mem(32'h0)) held++;
            advance();
        end
        chk("stall_reqs", 32'(hs), 4);
        chk("stall_hold", 32'(held), 8);
        ready  = 1'b1;
        exp_pc = 32'h0;
        pops   = 0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (valid) begin
                chk("drain_pc", pc, exp_pc);
                chk("drain_instr", instr, mem(exp_pc));
                exp_pc += 4;
                pops++;
            end
            advance();
        end
        chk("drain_pops", 32'(pops), 12);

        // Back-to-back redirects with one buffered and two fetches in flight.
        reset_dut();
        gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            lat = (c == 0) ? 1 : 4;
            settle();
            advance();
        end
        gnt   = 1'b0;
        redir = 1'b1;
        rpc   = 32'h2F0;
        settle();
        chk("redir1_req", 32'(req), 0);
        chk("redir1_valid", 32'(valid), 0);
        advance();
        rpc = 32'h103;
        settle();
        chk("redir2_valid", 32'(valid), 0);
        advance();
        redir = 1'b0;
        gnt   = 1'b1;
        ready = 1'b1;
        lat   = 1;
        settle();
        chk("redir_req", 32'(req), 1);
        chk("redir_addr", addr, 32'h100);
        advance();
        exp_pc = 32'h100;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            settle();
            if (valid) begin
                chk("redir_pc", pc, exp_pc);
                chk("redir_instr", instr, mem(exp_pc));
                exp_pc += 4;
                done = exp_pc == 32'h10C;
            end
            advance();
        end
        chk("redir_timeout", 32'(done), 1);

        // Random grant/latency/ready/redirect with a mid-stream reset.
        reset_dut();
        exp_fpc = 32'h0;
        exp_pc  = 32'h0;
        pops    = 0;
        for (int c = 0; c < 400; c++) begin
            rst   = c == 200;
            gnt   = ($urandom % 4) != 0;
            ready = ($urandom % 3) != 0;
            redir = !rst && c > 5 && ($urandom % 37) == 0;
            rpc   = $urandom & 32'h0000_FFFF;
            lat   = $urandom_range(1, 3);
            settle();
            if (c == 201) begin
                chk("rnd_rst_valid", 32'(valid), 0);
                chk("rnd_rst_instr", instr, 0);
                chk("rnd_rst_pc", pc, 0);
                chk("rnd_rst_addr", addr, 0);
            end
            if (rst) chk("rnd_rst_req", 32'(req), 0);
            else if (redir) begin
                chk("rnd_redir_req", 32'(req), 0);
                chk("rnd_redir_valid", 32'(valid), 0);
                exp_fpc = {rpc[31:2], 2'b00};
                exp_pc  = exp_fpc;
            end else begin
                if (req && gnt) begin
                    chk("rnd_addr", addr, exp_fpc);
                    exp_fpc += 4;
                end
                if (valid && ready) begin
                    chk("rnd_pc", pc, exp_pc);
                    chk("rnd_instr", instr, mem(exp_pc));
                    exp_pc += 4;
                    pops++;
                end
            end
            if (rst) begin
                exp_fpc = 32'h0;
                exp_pc  = 32'h0;
            end
            advance();
        end
        rst   = 1'b0;
        redir = 1'b0;
        chk("rnd_progress", 32'(pops >= 60), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
